// File: rtl/jtag_ir_pkg.sv
// jtag_ir_pkg: shared constants and types for the parametrised JTAG IR.
//   IR_IDCODE/IR_DTMCS/IR_DMI : 8-bit opcodes, zero-extended or truncated to IR_WIDTH
//   IR_CAPTURE_LSBS           : fixed low bits loaded on Capture-IR
//   ir_sel_t                  : one-hot instruction select group
package jtag_ir_pkg;
  localparam logic [7:0] IR_IDCODE       = 8'h01;
  localparam logic [7:0] IR_DTMCS        = 8'h10;
  localparam logic [7:0] IR_DMI          = 8'h11;
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  typedef struct packed {
    logic idcode;
    logic dtmcs;
    logic dmi;
    logic bypass;
  } ir_sel_t;

  localparam ir_sel_t SEL_IDCODE = ir_sel_t'(4'b1000);
endpackage

// File: rtl/jtag_ir_decode.sv
// jtag_ir_decode: combinational opcode -> one-hot select.
//   opcode : IR_WIDTH-bit instruction
//   sel    : one-hot select; anything unrecognised (incl. 0 and all-ones) folds to bypass
module jtag_ir_decode
  import jtag_ir_pkg::*;
#(
  parameter int IR_WIDTH = 8
) (
  input  logic [IR_WIDTH-1:0] opcode,
  output ir_sel_t             sel
);
  always_comb begin
    sel = '0;
    if (opcode == IR_WIDTH'(IR_IDCODE))     sel.idcode = 1'b1;
    else if (opcode == IR_WIDTH'(IR_DTMCS)) sel.dtmcs  = 1'b1;
    else if (opcode == IR_WIDTH'(IR_DMI))   sel.dmi    = 1'b1;
    else                                    sel.bypass = 1'b1;
  end
endmodule

// File: rtl/jtag_ir_param.sv
// jtag_ir_param: parametrised JTAG instruction register with TLR handling,
// short-shift rejection, status capture and registered one-hot decode.
// Optional macro JTAG_IR_PARITY_EN adds an odd-parity bit shifted in last.
//   clk, rst          : TCK clock, synchronous active-high reset
//   tlr               : Test-Logic-Reset, same effect as rst
//   capture_ir/shift_ir/update_ir : TAP state strobes
//   tdi, tdo          : serial in / out (tdo = shift_reg[0])
//   status_in         : captured into shift_reg[IR_WIDTH-1:3]
//   ir_out, sel_*     : latched instruction and its one-hot decode
//   ir_update_pulse   : one cycle after each accepted update
//   short_err         : sticky reject flag, cleared by capture
module jtag_ir_param
  import jtag_ir_pkg::*;
#(
  parameter int                  IR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] RESET_IR = IR_WIDTH'(8'h01)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tlr,
  input  logic                tdi,
  output logic                tdo,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic [IR_WIDTH-4:0] status_in,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                sel_idcode,
  output logic                sel_dtmcs,
  output logic                sel_dmi,
  output logic                sel_bypass,
  output logic                ir_update_pulse,
  output logic                short_err
);
`ifdef JTAG_IR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SR_W  = IR_WIDTH + PAR_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);

  if (IR_WIDTH < 5 || IR_WIDTH > 16) begin : g_bad_width
    $error("jtag_ir_param: IR_WIDTH must be 5..16");
  end

  logic [SR_W-1:0]     shift_reg;
  logic [CNT_W-1:0]    shift_cnt;
  logic [IR_WIDTH-1:0] ir_q;
  ir_sel_t             sel_q, dec_sel;
  logic                pulse_q, err_q;
  logic                par_ok, len_ok, accept, reject;

`ifdef JTAG_IR_PARITY_EN
  assign par_ok = ^shift_reg;
`else
  assign par_ok = 1'b1;
`endif
  assign len_ok = (shift_cnt == CNT_FULL);

  // Capture/shift outrank update, so an accept needs update alone. A reject
  // still sets short_err when overlapping capture so the error is not lost.
  assign accept = update_ir & ~capture_ir & ~shift_ir & len_ok & par_ok;
  assign reject = update_ir & ~shift_ir & ~(len_ok & par_ok);

  jtag_ir_decode #(.IR_WIDTH(IR_WIDTH)) u_dec (
    .opcode (shift_reg[IR_WIDTH-1:0]),
    .sel    (dec_sel)
  );

  always_ff @(posedge clk) begin
    if (rst || tlr) begin
      shift_reg <= SR_W'(RESET_IR);
      shift_cnt <= '0;
      ir_q      <= RESET_IR;
      sel_q     <= SEL_IDCODE;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pulse_q <= accept;
      if (reject)          err_q <= 1'b1;
      else if (capture_ir) err_q <= 1'b0;

      if (capture_ir) begin
        // zero-extension leaves the parity bit (if present) at 0
        shift_reg <= SR_W'({status_in, err_q, IR_CAPTURE_LSBS});
        shift_cnt <= '0;
      end else if (shift_ir) begin
        shift_reg <= {tdi, shift_reg[SR_W-1:1]};
        if (shift_cnt != CNT_FULL) shift_cnt <= shift_cnt + CNT_W'(1);
      end else if (update_ir) begin
        shift_cnt <= '0;
        if (accept) begin
          ir_q  <= shift_reg[IR_WIDTH-1:0];
          sel_q <= dec_sel;
        end
      end
    end
  end

  assign tdo             = shift_reg[0];
  assign ir_out          = ir_q;
  assign sel_idcode      = sel_q.idcode;
  assign sel_dtmcs       = sel_q.dtmcs;
  assign sel_dmi         = sel_q.dmi;
  assign sel_bypass      = sel_q.bypass;
  assign ir_update_pulse = pulse_q;
  assign short_err       = err_q;
endmodule

// File: tb/tb_jtag_ir_param.sv
// tb_jtag_ir_param: directed, table-driven bench for jtag_ir_param at
// IR_WIDTH=8, plus a shared-stimulus IR_WIDTH=5 instance.
module tb_jtag_ir_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tlr, tdi, capture_ir, shift_ir, update_ir;
  logic [4:0] status_in;
  logic [1:0] status5;

  logic       tdo, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass, pulse, short_err;
  logic [7:0] ir_out;
  logic       tdo5, sel5_idcode, sel5_dtmcs, sel5_dmi, sel5_bypass, pulse5, err5;
  logic [4:0] ir5;

  jtag_ir_param #(.IR_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .tlr(tlr), .tdi(tdi), .tdo(tdo),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .status_in(status_in), .ir_out(ir_out),
    .sel_idcode(sel_idcode), .sel_dtmcs(sel_dtmcs), .sel_dmi(sel_dmi),
    .sel_bypass(sel_bypass), .ir_update_pulse(pulse), .short_err(short_err)
  );

  jtag_ir_param #(.IR_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .tlr(tlr), .tdi(tdi), .tdo(tdo5),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .status_in(status5), .ir_out(ir5),
    .sel_idcode(sel5_idcode), .sel_dtmcs(sel5_dtmcs), .sel_dmi(sel5_dmi),
    .sel_bypass(sel5_bypass), .ir_update_pulse(pulse5), .short_err(err5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;      // bits shifted LSB-first
    int          n;      // data bits shifted (parity appended when enabled)
    logic [7:0]  ir;     // expected ir_out
    logic [3:0]  sel;    // expected {idcode,dtmcs,dmi,bypass}
    logic        pulse;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_capture();
    capture_ir = 1'b1; tick(); capture_ir = 1'b0;
  endtask

  task automatic shift_raw(input logic [15:0] d, input int n);
    shift_ir = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi = d[i];
      tick();
    end
    shift_ir = 1'b0;
    tdi = 1'b0;
  endtask

  // shifts n data bits; with parity enabled, appends the odd-parity bit
  // over the last w data bits
  task automatic shift_word(input logic [15:0] d, input int n, input int w);
    logic p;
    p = 1'b1;
    for (int i = 0; i < n; i++) if (i >= n - w) p = p ^ d[i];
    shift_raw(d, n);
`ifdef JTAG_IR_PARITY_EN
    shift_raw({15'b0, p}, 1);
`endif
  endtask

  function automatic logic [3:0] sel8();
    return {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    vecs[0] = '{16'h0011,  8, 8'h11, 4'b0010, 1'b1, 1'b0};
    vecs[1] = '{16'h0010,  8, 8'h10, 4'b0100, 1'b1, 1'b0};
    vecs[2] = '{16'h0001,  8, 8'h01, 4'b1000, 1'b1, 1'b0};
    vecs[3] = '{16'h03C5, 12, 8'h3C, 4'b0001, 1'b1, 1'b0};  // overshift, last 8 = 0x3C
    vecs[4] = '{16'h0010,  5, 8'h3C, 4'b0001, 1'b0, 1'b1};  // short shift
    vecs[5] = '{16'h0000,  8, 8'h00, 4'b0001, 1'b1, 1'b0};
    vecs[6] = '{16'h00FF,  8, 8'hFF, 4'b0001, 1'b1, 1'b0};
    vecs[7] = '{16'h0011,  7, 8'hFF, 4'b0001, 1'b0, 1'b1};  // one bit short
    vecs[8] = '{16'h0011,  8, 8'h11, 4'b0010, 1'b1, 1'b0};

    rst = 1'b1; tlr = 1'b0; tdi = 1'b0;
    capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    status_in = '0; status5 = '0;
    tick(); tick();
    chk("rst_ir",    {8'h0, ir_out}, 16'h0001);
    chk("rst_sel",   {12'h0, sel8()}, 16'h0008);
    chk("rst_err",   {15'h0, short_err}, 16'h0);
    chk("rst_tdo",   {15'h0, tdo}, 16'h1);
    chk("rst_pulse", {15'h0, pulse}, 16'h0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 9; k++) begin
      do_capture();
      shift_word(vecs[k].d, vecs[k].n, 8);
      update_ir = 1'b1; tick(); update_ir = 1'b0;
      chk($sformatf("v%0d_ir", k),    {8'h0, ir_out},      {8'h0, vecs[k].ir});
      chk($sformatf("v%0d_sel", k),   {12'h0, sel8()},     {12'h0, vecs[k].sel});
      chk($sformatf("v%0d_pulse", k), {15'h0, pulse},      {15'h0, vecs[k].pulse});
      chk($sformatf("v%0d_err", k),   {15'h0, short_err},  {15'h0, vecs[k].err});
      tick();
      chk($sformatf("v%0d_pulse_off", k), {15'h0, pulse}, 16'h0);
    end

    // capture pattern with short_err set: {10110,1,01} = 0xB5, read-to-clear
    do_capture();
    shift_raw(16'h0, 3);
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("cap_pre_err", {15'h0, short_err}, 16'h1);
    status_in = 5'b10110;
    do_capture();
    status_in = '0;
    chk("cap_err_clr", {15'h0, short_err}, 16'h0);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      got[i] = tdo;
      shift_raw(16'h0, 1);
    end
    chk("cap_pattern", {8'h0, got}, 16'h00B5);
    do_capture();

    // TLR mid-shift clears ir and a pending short_err
    shift_word(16'h0010, 8, 8);
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("tlr_pre_ir", {8'h0, ir_out}, 16'h0010);
    do_capture();
    shift_raw(16'h0, 3);
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("tlr_pre_err", {15'h0, short_err}, 16'h1);
    shift_raw(16'h3, 2);
    tlr = 1'b1; tick(); tlr = 1'b0;
    chk("tlr_ir",  {8'h0, ir_out}, 16'h0001);
    chk("tlr_sel", {12'h0, sel8()}, 16'h0008);
    chk("tlr_err", {15'h0, short_err}, 16'h0);
    chk("tlr_tdo", {15'h0, tdo}, 16'h1);

    // update with no capture/shift is rejected
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("bare_upd_ir",    {8'h0, ir_out}, 16'h0001);
    chk("bare_upd_err",   {15'h0, short_err}, 16'h1);
    chk("bare_upd_pulse", {15'h0, pulse}, 16'h0);

    // IR_WIDTH=5 instance
    do_capture();
    shift_word(16'h001F, 5, 5);
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("w5_ir",    {11'h0, ir5}, 16'h001F);
    chk("w5_sel",   {12'h0, sel5_idcode, sel5_dtmcs, sel5_dmi, sel5_bypass}, 16'h0001);
    chk("w5_pulse", {15'h0, pulse5}, 16'h1);
    do_capture();
    shift_word(16'h0011, 5, 5);
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("w5_dmi_ir",  {11'h0, ir5}, 16'h0011);
    chk("w5_dmi_sel", {12'h0, sel5_idcode, sel5_dtmcs, sel5_dmi, sel5_bypass}, 16'h0002);

`ifdef JTAG_IR_PARITY_EN
    do_capture();
    shift_raw(16'h0010, 9);   // parity bit 0, total ones odd
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("par_ok_ir",    {8'h0, ir_out}, 16'h0010);
    chk("par_ok_sel",   {12'h0, sel8()}, 16'h0004);
    chk("par_ok_pulse", {15'h0, pulse}, 16'h1);
    do_capture();
    shift_raw(16'h0110, 9);   // parity bit 1, total ones even
    update_ir = 1'b1; tick(); update_ir = 1'b0;
    chk("par_bad_ir",    {8'h0, ir_out}, 16'h0010);
    chk("par_bad_err",   {15'h0, short_err}, 16'h1);
    chk("par_bad_pulse", {15'h0, pulse}, 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
